pipe_scoreboard: RTL
====================

Name: pipe_scoreboard

Overview:
- Parametrised successor to the fixed hazard/forwarding pair in the 5-stage MIPS pipeline.
- Tracks every in-flight register write across variable-latency execute paths: ALU = 1 cycle, load = 2, multiply up to MAX_LAT.
- Decides per cycle whether the instruction in decode may issue, and which source operands take the writeback bypass.
- Sits between ID_Stage and ID_Stage_reg; drives the stall, and the writeback-side dest/valid tags.

Parameters:
- NUM_REGS, 32, architectural registers; register 0 is never tracked.
- REG_AW, 5, register address width (clog2 NUM_REGS).
- NUM_SRC, 2, source operands checked per issue.
- MAX_LAT, 4, longest issue-to-writeback latency in cycles (>=1).
- LAT_W, clog2(MAX_LAT+1), latency field width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- issue_valid  in  1  decode holds a valid instruction.
- issue_src  in  NUM_SRC*REG_AW  source register numbers, src k at bits [k*REG_AW +: REG_AW].
- issue_src_used  in  NUM_SRC  per-source "operand actually read"; replaces the Is_Imm special case.
- issue_wb_en  in  1  instruction writes a register.
- issue_dest  in  REG_AW  destination register.
- issue_lat  in  LAT_W  writeback latency; 0 is treated as 1, values >MAX_LAT are treated as MAX_LAT.
- flush  in  1  branch taken; squashes this cycle's issue.
- issue_stall  out  1  hold IF/ID, bubble ID/EX.
- issue_accept  out  1  instruction enters the pipe this cycle.
- fwd_hit  out  NUM_SRC  per-source select for the writeback bypass.
- wb_valid  out  1  slot 0 occupied, meaning a register write happens this cycle.
- wb_dest  out  REG_AW  register written this cycle.
- inflight_cnt  out  LAT_W  number of occupied slots.
- stall_cycles  out  32  saturating count of cycles with issue_stall=1.

Behaviour:
- State is the slot array s[0..MAX_LAT-1], each slot {v, dest}.
  - The index is cycles remaining until writeback.
  - Slot 0 is the instruction writing back in the current cycle.
- Effective latency L = clamp(issue_lat, 1, MAX_LAT).
- The new instruction is tracked only if T = issue_valid & issue_wb_en & (issue_dest != 0).
- Stall terms, all combinational from the current slots:
  - RAW: a source k is active when issue_src_used[k] and issue_src[k] != 0. Stall if any active source equals s[i].dest with s[i].v and i >= 1.
  - Structural: T and s[L].v, for L < MAX_LAT. That entry would land in slot L-1 together with the new instruction.
  - WAW: T and there is an s[i].v with s[i].dest == issue_dest and i > L. The older instruction would overwrite the newer result.
  - issue_stall = issue_valid & ~flush & (RAW | struct | WAW).
- issue_accept = issue_valid & ~flush & ~issue_stall.
- Clock edge update:
  - For i < MAX_LAT-1: s[i] <= s[i+1]. s[MAX_LAT-1] <= 0.
  - Then, if issue_accept & T: s[L-1] <= {1, issue_dest}.
  - An instruction accepted at cycle t shows wb_valid at cycle t+L.
- wb_valid = s[0].v and wb_dest = s[0].dest. Both are registered-state outputs, not combinational from the inputs.
- inflight_cnt is the popcount of s[*].v.
- stall_cycles increments on each issue_stall=1 cycle and saturates at 2^32-1.
- flush: no stall, no insert; in-flight slots are unaffected because they have already passed EXE.
- Reset: all slots clear; issue_stall, issue_accept, fwd_hit, wb_valid, wb_dest, inflight_cnt and stall_cycles read 0 in the cycle after rst. A reset mid-operation discards all pending writes.
- Source equal to 0, or an unused source: never stalls, never forwards.
- Two sources naming the same register are evaluated independently and give identical results.

Optional Feature:
- Macro SCB_FWD_EN.
- Defined: an active source equal to s[0].dest with s[0].v is not a stall; fwd_hit[k]=1 and EXE takes the WB_Data bypass.
- Undefined: fwd_hit is tied to 0. A slot-0 match is added to the RAW stall, and the instruction issues the next cycle, after the register-file write edge.

Decomposition:
- Package scb_pkg holds:
  - the slot struct {v, dest};
  - the functions clamp_lat and popcount;
  - the constant REG_ZERO = 0.
- One sub-module, scb_match: given one source and the slot array, returns {raw_hit_future, raw_hit_wb}. It is instantiated NUM_SRC times with a generate loop.

Test Plan:
- Back-to-back dependency: issue dest=3 L=1, then next cycle src0=3.
  - With SCB_FWD_EN: no stall, fwd_hit[0]=1.
  - Without SCB_FWD_EN: one stall cycle, then accept.
- Load-use: issue dest=5 L=2, next cycle src1=5 used. Required: one stall cycle, then accept with fwd_hit[1]=1 (FWD_EN).
- Structural: issue dest=7 L=3 at t, then dest=8 L=2 at t+1. Required: stall at t+1, accept at t+2, wb_valid for reg 7 at t+3 and reg 8 at t+4.
- WAW: issue dest=9 L=4, next cycle dest=9 L=1. Required: stall until slot clears; wb_dest sequence 9, 9 in order, never inverted.
- Register 0 and unused source:
  - dest=0 L=4 leaves inflight_cnt at 0.
  - src=0, or issue_src_used=0 against pending reg 4, gives no stall.
- Flush and reset: flush with issue_valid gives issue_accept=0 and stall=0. rst asserted with 3 in-flight entries gives inflight_cnt=0, wb_valid=0 and stall_cycles=0 on the next cycle.

Source files
------------

// File: rtl/pipe_scoreboard_pkg.sv
// Shared types, constants and helpers for the pipeline writeback scoreboard.
// The slot struct is sized by SCB_REG_AW, so the top must keep REG_AW equal to it.
package scb_pkg;

  localparam int SCB_NUM_REGS = 32;
  localparam int SCB_REG_AW   = $clog2(SCB_NUM_REGS);
  localparam int SCB_NUM_SRC  = 2;
  localparam int SCB_MAX_LAT  = 4;
  localparam int SCB_LAT_W    = $clog2(SCB_MAX_LAT + 1);

  localparam logic [SCB_REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                  v;
    logic [SCB_REG_AW-1:0] dest;
  } slot_t;

  // Latency 0 behaves like a single-cycle ALU op; anything longer than the
  // deepest path is folded onto that path.
  function automatic int clamp_lat(input int lat, input int maxLat);
    if (lat < 1) begin
      return 1;
    end
    if (lat > maxLat) begin
      return maxLat;
    end
    return lat;
  endfunction

  function automatic int popcount(input logic [31:0] bits);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cnt += int'(bits[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/pipe_scoreboard_if.sv
// Decode-to-scoreboard issue bus plus the writeback-side status returned to the pipe.
// master = decode stage, slave = scoreboard.
interface pipe_scoreboard_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int LAT_W   = 3
);

  logic                        issue_valid;
  logic [NUM_SRC*REG_AW-1:0]   issue_src;
  logic [NUM_SRC-1:0]          issue_src_used;
  logic                        issue_wb_en;
  logic [REG_AW-1:0]           issue_dest;
  logic [LAT_W-1:0]            issue_lat;
  logic                        flush;

  logic                        issue_stall;
  logic                        issue_accept;
  logic [NUM_SRC-1:0]          fwd_hit;
  logic                        wb_valid;
  logic [REG_AW-1:0]           wb_dest;
  logic [LAT_W-1:0]            inflight_cnt;
  logic [31:0]                 stall_cycles;

  modport master (
    output issue_valid, issue_src, issue_src_used, issue_wb_en,
           issue_dest, issue_lat, flush,
    input  issue_stall, issue_accept, fwd_hit, wb_valid, wb_dest,
           inflight_cnt, stall_cycles
  );

  modport slave (
    input  issue_valid, issue_src, issue_src_used, issue_wb_en,
           issue_dest, issue_lat, flush,
    output issue_stall, issue_accept, fwd_hit, wb_valid, wb_dest,
           inflight_cnt, stall_cycles
  );

endinterface

// File: rtl/pipe_scoreboard_match.sv
// Compares one decode source operand against every in-flight writeback slot.
// rawHitFuture: producer still in EXE/MEM; rawHitWb: producer writes back this cycle.
module scb_match
  import scb_pkg::*;
#(
  parameter int REG_AW  = SCB_REG_AW,
  parameter int MAX_LAT = SCB_MAX_LAT
) (
  input  logic [REG_AW-1:0] src,
  input  logic              srcUsed,
  input  slot_t             slots [MAX_LAT],
  output logic              rawHitFuture,
  output logic              rawHitWb
);

  logic active;

  // Register 0 and operands the instruction does not read can never create a hazard.
  always_comb begin
    active       = srcUsed && (src != REG_ZERO);
    rawHitFuture = 1'b0;
    for (int i = 1; i < MAX_LAT; i++) begin
      if (active && slots[i].v && (slots[i].dest == src)) begin
        rawHitFuture = 1'b1;
      end
    end
    rawHitWb = active && slots[0].v && (slots[0].dest == src);
  end

endmodule

// File: rtl/pipe_scoreboard.sv
// Issue scoreboard for variable-latency execute paths: RAW/structural/WAW stall and WB bypass.
// Optional macro SCB_FWD_EN enables the writeback bypass instead of stalling on slot-0 matches.
module pipe_scoreboard
  import scb_pkg::*;
#(
  parameter int NUM_REGS = SCB_NUM_REGS,
  parameter int REG_AW   = $clog2(NUM_REGS),
  parameter int NUM_SRC  = SCB_NUM_SRC,
  parameter int MAX_LAT  = SCB_MAX_LAT,
  parameter int LAT_W    = $clog2(MAX_LAT + 1)
) (
  input logic                clk,
  input logic                rst,
  pipe_scoreboard_if.slave   bus
);

  slot_t              slots_q [MAX_LAT];
  slot_t              slots_d [MAX_LAT];
  logic [31:0]        stallCount_q;
  logic [31:0]        stallCount_d;

  logic [NUM_SRC-1:0] hitFuture;
  logic [NUM_SRC-1:0] hitWb;
  logic [MAX_LAT-1:0] validBits;
  int                 effLat;
  logic               trackNew;
  logic               rawStall;
  logic               structStall;
  logic               wawStall;
  logic               stall;
  logic               accept;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_match
    scb_match #(
      .REG_AW  (REG_AW),
      .MAX_LAT (MAX_LAT)
    ) u_match (
      .src          (bus.issue_src[k*REG_AW +: REG_AW]),
      .srcUsed      (bus.issue_src_used[k]),
      .slots        (slots_q),
      .rawHitFuture (hitFuture[k]),
      .rawHitWb     (hitWb[k])
    );
  end

  // Issue decision: a new write lands in slot L-1 after the shift, so slot L must be
  // free now, and no older write to the same register may still sit beyond slot L.
  always_comb begin
    effLat   = clamp_lat(int'(bus.issue_lat), MAX_LAT);
    trackNew = bus.issue_valid && bus.issue_wb_en && (bus.issue_dest != REG_ZERO);
    rawStall = |hitFuture;
`ifndef SCB_FWD_EN
    rawStall = rawStall || (|hitWb);
`endif
    structStall = 1'b0;
    wawStall    = 1'b0;
    for (int i = 1; i < MAX_LAT; i++) begin
      if (trackNew && (i == effLat) && slots_q[i].v) begin
        structStall = 1'b1;
      end
    end
    for (int i = 0; i < MAX_LAT; i++) begin
      if (trackNew && (i > effLat) && slots_q[i].v && (slots_q[i].dest == bus.issue_dest)) begin
        wawStall = 1'b1;
      end
    end
    stall  = bus.issue_valid && !bus.flush && (rawStall || structStall || wawStall);
    accept = bus.issue_valid && !bus.flush && !stall;
  end

  // Every slot moves one step closer to writeback; an accepted write enters behind it.
  always_comb begin
    for (int i = 0; i < MAX_LAT - 1; i++) begin
      slots_d[i] = slots_q[i+1];
    end
    slots_d[MAX_LAT-1] = '0;
    if (accept && trackNew) begin
      for (int i = 0; i < MAX_LAT; i++) begin
        if (i == effLat - 1) begin
          slots_d[i].v    = 1'b1;
          slots_d[i].dest = bus.issue_dest;
        end
      end
    end
    stallCount_d = stallCount_q;
    if (stall && (stallCount_q != '1)) begin
      stallCount_d = stallCount_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_LAT; i++) begin
        slots_q[i] <= '0;
      end
      stallCount_q <= '0;
    end else begin
      slots_q      <= slots_d;
      stallCount_q <= stallCount_d;
    end
  end

  always_comb begin
    for (int i = 0; i < MAX_LAT; i++) begin
      validBits[i] = slots_q[i].v;
    end
  end

  assign bus.issue_stall  = stall;
  assign bus.issue_accept = accept;
  assign bus.wb_valid     = slots_q[0].v;
  assign bus.wb_dest      = slots_q[0].dest;
  assign bus.inflight_cnt = LAT_W'(popcount(32'(validBits)));
  assign bus.stall_cycles = stallCount_q;

`ifdef SCB_FWD_EN
  assign bus.fwd_hit = hitWb & {NUM_SRC{bus.issue_valid && !bus.flush}};
`else
  assign bus.fwd_hit = '0;
`endif

endmodule
